// File: rtl/scalar_divide_if.sv
// Request/response bundle for the scalar-divide ALU op.
//   start        : request, sampled only while the block is idle
//   matrix_a     : packed signed elements, element i at [i*DATA_W +: DATA_W]
//   integer_num  : signed scalar divisor
//   matrix_size  : 00=2x2, 01=3x3, 10=4x4, 11=5x5
//   new_matrix   : signed quotients, inactive lanes 0
//   overflow_flag, div_zero_flag, busy, done : status
// master drives the request side, slave is the divider.
interface scalar_divide_if #(
  parameter int DATA_W = 8
);
  localparam int MAT_W = 25 * DATA_W;

  logic              start;
  logic [MAT_W-1:0]  matrix_a;
  logic [DATA_W-1:0] integer_num;
  logic [1:0]        matrix_size;
  logic [MAT_W-1:0]  new_matrix;
  logic              overflow_flag;
  logic              div_zero_flag;
  logic              busy;
  logic              done;

  modport master (
    output start, matrix_a, integer_num, matrix_size,
    input  new_matrix, overflow_flag, div_zero_flag, busy, done
  );

  modport slave (
    input  start, matrix_a, integer_num, matrix_size,
    output new_matrix, overflow_flag, div_zero_flag, busy, done
  );
endinterface

// File: rtl/scalar_divide.sv
// Sequential element-wise division of a packed signed matrix (2x2..5x5) by
// a signed scalar. One bit-serial restoring divider is shared by all lanes:
// per element SETUP (1) + DIV (DATA_W) + WRITE (1) cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : scalar_divide_if.slave (start/done handshake, operands, results)
module scalar_divide #(
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  scalar_divide_if.slave  bus
);
  localparam int LANES = 25;
  localparam int MAT_W = LANES * DATA_W;
  localparam int STEP_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, DIV, WRITE, FINISH} state_t;

  state_t            state;
  logic [MAT_W-1:0]  a_r;
  logic [DATA_W-1:0] d_r;
  logic [4:0]        j, last;
  logic [STEP_W-1:0] step;
  // dvd shifts out dividend bits MSB first and shifts in quotient bits, so it
  // holds the unsigned quotient magnitude once DIV completes.
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dsr;
  logic [DATA_W-1:0] rem;
  logic              neg;

  logic [MAT_W-1:0]  nm_r;
  logic              ovf_r, dz_r, busy_r, done_r;

  logic [DATA_W-1:0] elem, elem_mag, div_mag, rem_nxt, qval;
  logic [DATA_W:0]   trial;
  logic              ge, ovf_now;

  // Magnitudes are unsigned DATA_W-bit values, so |-128| = 128 is exact;
  // the trial remainder and compare run one bit wider.
  always_comb begin
    elem     = a_r[j*DATA_W +: DATA_W];
    elem_mag = elem[DATA_W-1] ? (~elem + 1'b1) : elem;
    div_mag  = d_r[DATA_W-1] ? (~d_r + 1'b1) : d_r;
    trial    = {rem, dvd[DATA_W-1]};
    ge       = (trial >= {1'b0, dsr});
    rem_nxt  = ge ? DATA_W'(trial - {1'b0, dsr}) : trial[DATA_W-1:0];
    qval     = neg ? (~dvd + 1'b1) : dvd;
    // Magnitude tops out at 128; positive 128 only arises from -128 / -1.
    ovf_now  = ~neg & dvd[DATA_W-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_r    <= '0;
      d_r    <= '0;
      j      <= '0;
      last   <= '0;
      step   <= '0;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      neg    <= 1'b0;
      nm_r   <= '0;
      ovf_r  <= 1'b0;
      dz_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          a_r    <= bus.matrix_a;
          d_r    <= bus.integer_num;
          case (bus.matrix_size)
            2'b00:   last <= 5'd3;
            2'b01:   last <= 5'd8;
            2'b10:   last <= 5'd15;
            default: last <= 5'd24;
          endcase
          j      <= '0;
          nm_r   <= '0;
          ovf_r  <= 1'b0;
          dz_r   <= 1'b0;
          busy_r <= 1'b1;
          state  <= (bus.integer_num == '0) ? FINISH : SETUP;
        end
        SETUP: begin
          dvd   <= elem_mag;
          dsr   <= div_mag;
          rem   <= '0;
          neg   <= elem[DATA_W-1] ^ d_r[DATA_W-1];
          step  <= '0;
          state <= DIV;
        end
        DIV: begin
          rem   <= rem_nxt;
          dvd   <= {dvd[DATA_W-2:0], ge};
          step  <= step + 1'b1;
          if (step == STEP_W'(DATA_W - 1)) state <= WRITE;
        end
        WRITE: begin
          // A zero magnitude negates to zero, so -0 never appears.
          nm_r[j*DATA_W +: DATA_W] <= qval;
          if (ovf_now) ovf_r <= 1'b1;
          if (j == last) state <= FINISH;
          else begin
            j     <= j + 1'b1;
            state <= SETUP;
          end
        end
        FINISH: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
          dz_r   <= (d_r == '0);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.new_matrix    = nm_r;
  assign bus.overflow_flag = ovf_r;
  assign bus.div_zero_flag = dz_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
endmodule

// File: tb/tb_scalar_divide.sv
module tb_scalar_divide;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scalar_divide_if #(.DATA_W(8)) bus ();
  scalar_divide #(.DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct packed {
    logic [199:0] m;
    logic         ovf;
    logic         dz;
  } res_t;

  typedef struct packed {
    logic [199:0] a;
    logic [7:0]   d;
    logic [1:0]   sz;
    logic [199:0] em;
    logic         eo;
    logic         ez;
    int           lat;
    logic         pulse;
  } vec_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [199:0] put(input logic [199:0] m, input int i, input int v);
    logic [199:0] r;
    r = m;
    r[i*8 +: 8] = v[7:0];
    return r;
  endfunction

  function automatic logic [199:0] mk4(input int b0, input int b1, input int b2, input int b3);
    return put(put(put(put('0, 0, b0), 1, b1), 2, b2), 3, b3);
  endfunction

  // Reference: integer division truncates toward zero.
  function automatic res_t model(input logic [199:0] a, input logic [7:0] d, input logic [1:0] sz);
    res_t r;
    int n, x, y, q;
    r = '0;
    n = (int'(sz) + 2) * (int'(sz) + 2);
    if (d == 8'd0) r.dz = 1'b1;
    else for (int k = 0; k < n; k++) begin
      x = int'($signed(a[k*8 +: 8]));
      y = int'($signed(d));
      q = x / y;
      r.m[k*8 +: 8] = q[7:0];
      if (q > 127 || q < -128) r.ovf = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(posedge clk) begin
    res_t e;
    #1;
    if (bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 200'd1, 200'd0);
      else begin
        e = sb.pop_front();
        chk("new_matrix", bus.new_matrix, e.m);
        chk("overflow_flag", {199'd0, bus.overflow_flag}, {199'd0, e.ovf});
        chk("div_zero_flag", {199'd0, bus.div_zero_flag}, {199'd0, e.dz});
      end
    end
  end

  task automatic drive(input logic [199:0] a, input logic [7:0] d, input logic [1:0] sz);
    bus.matrix_a    = a;
    bus.integer_num = d;
    bus.matrix_size = sz;
    bus.start       = 1'b1;
  endtask

  task automatic run_op(input vec_t v);
    int  lat;
    bit  busy_ok;
    @(negedge clk);
    drive(v.a, v.d, v.sz);
    sb.push_back('{m: v.em, ovf: v.eo, dz: v.ez});
    @(posedge clk);               // E0
    #1;
    chk("busy_after_start", {199'd0, bus.busy}, 200'd1);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 300 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (v.pulse && k == 19) begin
        drive({25{8'h11}}, 8'd1, 2'b11);
      end
      if (v.pulse && k == 20) bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        if (bus.busy) busy_ok = 1'b0;
      end else if (!bus.busy) busy_ok = 1'b0;
    end
    chk("done_latency", 200'(lat), 200'(v.lat));
    chk("busy_window", {199'd0, busy_ok}, 200'd1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {199'd0, bus.done}, 200'd0);
  endtask

  vec_t tbl[6];
  vec_t v;
  logic [199:0] a5, e5, a3;
  res_t r;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.matrix_a = '0;
    bus.integer_num = '0;
    bus.matrix_size = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_matrix", bus.new_matrix, 200'd0);
    chk("reset_status", {196'd0, bus.busy, bus.done, bus.overflow_flag, bus.div_zero_flag}, 200'd0);
    @(negedge clk);
    reset = 1'b0;

    a5 = '0;
    e5 = '0;
    for (int i = 0; i < 25; i++) begin
      a5 = put(a5, i, i - 12);
      e5 = put(e5, i, (i - 12) / 3);
    end
    a3 = {16{8'h5A}};
    a3 = a3 << 72;
    a3 = a3 | 200'(72'h01_00_F9_07_CE_32_81_7F_80);

    tbl[0] = '{a: mk4(10, -7, 127, 0), d: 8'd2, sz: 2'b00, em: mk4(5, -3, 63, 0),
               eo: 1'b0, ez: 1'b0, lat: 41, pulse: 1'b0};
    tbl[1] = '{a: mk4(-128, 6, -1, 100), d: 8'hFF, sz: 2'b00, em: mk4(-128, -6, 1, -100),
               eo: 1'b1, ez: 1'b0, lat: 41, pulse: 1'b0};
    tbl[2] = '{a: mk4(-128, 6, -1, 100), d: 8'd1, sz: 2'b00, em: mk4(-128, 6, -1, 100),
               eo: 1'b0, ez: 1'b0, lat: 41, pulse: 1'b0};
    tbl[3] = '{a: {25{8'h37}}, d: 8'd0, sz: 2'b11, em: '0,
               eo: 1'b0, ez: 1'b1, lat: 1, pulse: 1'b0};
    tbl[4] = '{a: a5, d: 8'd3, sz: 2'b11, em: e5,
               eo: 1'b0, ez: 1'b0, lat: 251, pulse: 1'b0};
    // -128/-128 = 1, everything else in the 3x3 truncates to 0; lanes 9..24 carry junk
    tbl[5] = '{a: a3, d: 8'h80, sz: 2'b01, em: 200'd1,
               eo: 1'b0, ez: 1'b0, lat: 91, pulse: 1'b0};

    for (int t = 0; t < 6; t++) run_op(tbl[t]);

    // 5x5 lanes spot-checked by hand after re-running the i-12 case.
    run_op(tbl[4]);
    chk("lane0_m12_div3", 200'(bus.new_matrix[7:0]), 200'(8'hFC));
    chk("lane1_m11_div3", 200'(bus.new_matrix[15:8]), 200'(8'hFD));
    chk("lane10_m2_div3", 200'(bus.new_matrix[87:80]), 200'd0);
    chk("lane24_12_div3", 200'(bus.new_matrix[199:192]), 200'd4);
    repeat (3) @(posedge clk);
    #1;
    chk("result_hold", bus.new_matrix, e5);

    // Second start mid-operation is ignored.
    v = tbl[0];
    v.pulse = 1'b1;
    run_op(v);
    repeat (30) @(posedge clk);

    // Asynchronous reset mid 3x3: no done, outputs clear at once.
    @(negedge clk);
    drive(tbl[5].a, tbl[5].d, tbl[5].sz);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (55) @(posedge clk);
    #2;
    chk("busy_before_reset", {199'd0, bus.busy}, 200'd1);
    reset = 1'b1;
    #1;
    chk("reset_mid_matrix", bus.new_matrix, 200'd0);
    chk("reset_mid_status", {196'd0, bus.busy, bus.done, bus.overflow_flag, bus.div_zero_flag}, 200'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_op(tbl[5]);

    // Random 4x4 operands against the reference model.
    for (int t = 0; t < 4; t++) begin
      v = '0;
      for (int i = 0; i < 25; i++) v.a = put(v.a, i, int'($urandom_range(0, 255)));
      v.d = 8'($urandom_range(1, 255));
      if (t == 0) v.d = 8'hFF;
      v.sz = 2'b10;
      r = model(v.a, v.d, v.sz);
      v.em = r.m;
      v.eo = r.ovf;
      v.ez = r.dz;
      v.lat = 161;
      run_op(v);
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 200'(sb.size()), 200'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
